// File: rtl/cnn_window_mac.sv
// Window dot-product engine: multiplies each accepted convolution window by a
// resident weight set, adds bias, saturates (optional ReLU) and streams one
// 32-bit result per window through a small output FIFO.
module cnn_window_mac #(
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  localparam int unsigned WINDOW_SIZE = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned IdxW        = $clog2(WINDOW_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_start,
  input  logic                     relu_en,
  input  logic [31:0]              bias,
  input  logic                     weight_we,
  input  logic [IdxW-1:0]          weight_idx,
  input  logic [15:0]              weight_wdata,
  input  logic [WINDOW_SIZE*32-1:0] window,
  input  logic                     window_valid,
  input  logic                     window_finish,
  output logic                     window_stall,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [CNT_WIDTH-1:0]     result_cnt,
  output logic                     done
);

  localparam int unsigned SumW   = 32 + IdxW + 1;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CreditW = CountW + 1;

  logic signed [15:0]     weights_q [WINDOW_SIZE];
  logic                   s1_v_q, s2_v_q;
  logic signed [31:0]     prod_d [WINDOW_SIZE];
  logic signed [31:0]     prod_q [WINDOW_SIZE];
  logic signed [SumW-1:0] sum_d, sum_q;
  logic [31:0]            sat_res, s3_res;
  logic [31:0]            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]      count_q, count_d;
  logic [CreditW-1:0]     credit;
  logic [CNT_WIDTH-1:0]   result_cnt_q;
  logic                   armed_q;
  logic                   acc, push, pop;
  logic                   unused_window_hi;

  // Credits cover every window already in flight, so the FIFO can never overflow.
  always_comb begin
    credit       = CreditW'(count_q) + CreditW'(s1_v_q) + CreditW'(s2_v_q);
    window_stall = credit >= CreditW'(FIFO_DEPTH);
    acc          = window_valid & ~window_stall;
    push         = s2_v_q;
    res_valid    = count_q != '0;
    pop          = res_valid & res_ready;
    res_data     = res_valid ? mem_q[rd_ptr_q] : '0;
    result_cnt   = result_cnt_q;
    done         = armed_q & window_finish & ~window_valid & ~s1_v_q & ~s2_v_q &
                   (count_q == '0);
  end

  // Resident weight store; out-of-range slots are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WINDOW_SIZE; k++) weights_q[k] <= '0;
    end else if (weight_we && (32'(weight_idx) < WINDOW_SIZE)) begin
      weights_q[weight_idx] <= weight_wdata;
    end
  end

  // Stage 1 products: only the low 16 bits of each element carry data.
  always_comb begin
    unused_window_hi = 1'b0;
    for (int k = 0; k < WINDOW_SIZE; k++) begin
      prod_d[k] = 32'($signed(window[k*32 +: 16])) * 32'(weights_q[k]);
      unused_window_hi = unused_window_hi ^ (^window[k*32+16 +: 16]);
    end
  end

  // Stage 2 adder tree input: bias plus all products at full width.
  always_comb begin
    sum_d = SumW'($signed(bias));
    for (int k = 0; k < WINDOW_SIZE; k++) sum_d = sum_d + SumW'(prod_q[k]);
  end

  // Pipeline registers; the pipeline never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      sum_q  <= '0;
      for (int k = 0; k < WINDOW_SIZE; k++) prod_q[k] <= '0;
    end else begin
      s1_v_q <= acc;
      s2_v_q <= s1_v_q;
      if (acc) begin
        for (int k = 0; k < WINDOW_SIZE; k++) prod_q[k] <= prod_d[k];
      end
      if (s1_v_q) sum_q <= sum_d;
    end
  end

  // Stage 3: saturate to 32 bits, then optional ReLU.
  always_comb begin
    if ((sum_q[SumW-1:31] == '0) || (sum_q[SumW-1:31] == '1)) begin
      sat_res = sum_q[31:0];
    end else if (sum_q[SumW-1]) begin
      sat_res = 32'h8000_0000;
    end else begin
      sat_res = 32'h7FFF_FFFF;
    end
    s3_res = (relu_en && sat_res[31]) ? '0 : sat_res;
  end

  // Output FIFO occupancy.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output FIFO storage and pointers; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s3_res;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Result counter and completion arm; op_start wins over a coincident pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_cnt_q <= '0;
      armed_q      <= 1'b0;
    end else begin
      if (op_start)  result_cnt_q <= '0;
      else if (pop)  result_cnt_q <= result_cnt_q + 1'b1;
      if (op_start)  armed_q <= 1'b1;
      else if (done) armed_q <= 1'b0;
    end
  end

  fifo_no_overflow_a : assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q < CountW'(FIFO_DEPTH)));

endmodule
